// File: rtl/de0qsys_sw_poller.sv
// Polls a 4-bit switch bank over Avalon-MM, debounces it and raises change events with a valid/ready handshake.
// Optional registered irq output (evt_valid | overrun) when DE0QSYS_SW_POLLER_IRQ_EN is defined.
module de0qsys_sw_poller #(
  parameter int POLL_DIV       = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [3:0]  sw_state,
  output logic        evt_valid,
  output logic [3:0]  evt_data,
  output logic [3:0]  evt_changed,
  input  logic        evt_ready,
  output logic        overrun,
  input  logic        ovr_clr
`ifdef DE0QSYS_SW_POLLER_IRQ_EN
  ,
  output logic        irq
`endif
);

  // states: IDLE = count to next poll | READ = read strobe | CAPTURE = latch sample | EVAL = debounce and publish
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    EVAL    = 2'd3
  } state_t;

  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
  localparam logic [3:0]  DEB_TH    = 4'(DEBOUNCE_COUNT);

  state_t      state;
  state_t      state_next;
  logic [15:0] poll_cnt;
  logic        poll_hit;
  logic        capture_en;
  logic        eval_en;
  logic [3:0]  sample;
  logic [3:0]  cand;
  logic [3:0]  stable_cnt;
  logic [3:0]  stable_next;
  logic        evt_now;
  logic        evt_lost;
  logic        evt_accept;
  logic [27:0] unused_readdata;

  assign unused_readdata = avm_readdata[31:4];
  assign avm_address     = 2'b00;
  assign poll_hit        = enable && (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (poll_hit) state_next = READ;
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = EVAL;
      EVAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    avm_read   = 1'b0;
    capture_en = 1'b0;
    eval_en    = 1'b0;
    case (state)
      READ:    avm_read   = 1'b1;
      CAPTURE: capture_en = 1'b1;
      EVAL:    eval_en    = 1'b1;
      default: ;
    endcase
  end

  // counter only runs in IDLE while enabled, so a disable restarts the full poll interval
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     poll_cnt <= '0;
    else if ((state != IDLE) || !enable || poll_hit)  poll_cnt <= '0;
    else                                              poll_cnt <= poll_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        sample <= '0;
    else if (capture_en) sample <= avm_readdata[3:0];
  end

  always_comb begin
    if (sample == cand) stable_next = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
    else                stable_next = 4'd1;
    evt_now    = eval_en && (stable_next >= DEB_TH) && (sample != sw_state);
    evt_accept = evt_valid && evt_ready;
    evt_lost   = evt_now && evt_valid && !evt_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand       <= '0;
      stable_cnt <= '0;
    end else if (eval_en) begin
      cand       <= sample;
      stable_cnt <= stable_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sw_state <= '0;
    else if (evt_now) sw_state <= sample;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_changed <= '0;
    end else if (evt_now && !evt_lost) begin
      evt_valid   <= 1'b1;
      evt_data    <= sample;
      evt_changed <= sample ^ sw_state;
    end else if (evt_accept) begin
      evt_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      overrun <= 1'b0;
    else if (evt_lost) overrun <= 1'b1;
    else if (ovr_clr)  overrun <= 1'b0;
  end

`ifdef DE0QSYS_SW_POLLER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= evt_valid | overrun;
  end
`endif

endmodule
